// File: rtl/data_mem_stage.sv
// data_mem_stage: little-endian word/half/byte load-store data memory with error flag and store trace (clk, reset_n, we, mem_op, addr, wdata -> rdata, addr_err, wr_valid, wr_addr, wr_word)
module data_mem_stage #(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_word
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0] cur, merged, bmask, bdata;
  logic [15:0] half;
  logic [7:0] byt;
  logic [4:0] sh;
  logic is_word, is_half, commit;
  always_comb begin
    idx = addr[IDX_W+1:2];
    is_word = mem_op == 3'd0;
    is_half = mem_op == 3'd1 || mem_op == 3'd2;
    addr_err = (mem_op > 3'd4) | (is_word & |addr[1:0]) | (is_half & addr[0])
             | (addr >= 32'(4 * DEPTH_WORDS));
    cur = addr_err ? 32'd0 : mem[idx];
    sh = {addr[1:0], 3'b000};
    half = addr[1] ? cur[31:16] : cur[15:0];
    byt = 8'(cur >> sh);
    rdata = addr_err ? 32'd0 :
            is_word ? cur :
            mem_op == 3'd1 ? {{16{half[15]}}, half} :
            mem_op == 3'd2 ? {16'd0, half} :
            mem_op == 3'd3 ? {{24{byt[7]}}, byt} : {24'd0, byt};
    bmask = 32'hFF << sh;
    bdata = {24'd0, wdata[7:0]} << sh;
    merged = is_word ? wdata :
             is_half ? (addr[1] ? {wdata[15:0], cur[15:0]} : {cur[31:16], wdata[15:0]}) :
             (cur & ~bmask) | bdata;
    commit = we & ~addr_err;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
      wr_valid <= 1'b0;
      wr_addr <= 32'd0;
      wr_word <= 32'd0;
    end else begin
      wr_valid <= commit;
      if (commit) begin
        mem[idx] <= merged;
        wr_addr <= {addr[31:2], 2'b00};
        wr_word <= merged;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_stage.sv
// tb_data_mem_stage: directed scoreboard bench for data_mem_stage
module tb_data_mem_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic we = 1'b0;
  logic [2:0] mem_op = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata, wr_addr, wr_word;
  logic addr_err, wr_valid;
  logic [31:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;

  data_mem_stage dut (
    .clk(clk), .reset_n(reset_n), .we(we), .mem_op(mem_op), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_err(addr_err), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_word(wr_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic step(input string tag, input logic w, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee,
                      input logic ev, input logic [31:0] ea, input logic [31:0] ew);
    @(negedge clk);
    we = w; mem_op = op; addr = a; wdata = d;
    sb.push_back(er);
    sb.push_back({31'd0, ee});
    sb.push_back({31'd0, ev});
    sb.push_back(ea);
    sb.push_back(ew);
    #1;
    chk({tag, ".rdata"}, rdata);
    chk({tag, ".addr_err"}, {31'd0, addr_err});
    @(posedge clk);
    #1;
    chk({tag, ".wr_valid"}, {31'd0, wr_valid});
    chk({tag, ".wr_addr"}, wr_addr);
    chk({tag, ".wr_word"}, wr_word);
  endtask

  task automatic trace_zero(input string tag);
    sb.push_back(32'd0);
    sb.push_back(32'd0);
    sb.push_back(32'd0);
    chk({tag, ".wr_valid"}, {31'd0, wr_valid});
    chk({tag, ".wr_addr"}, wr_addr);
    chk({tag, ".wr_word"}, wr_word);
  endtask

  initial begin
    #1;
    trace_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("lw0",      0, LW,  32'h0,    32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step("lw_top",   0, LW,  32'h2FFC, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step("lb_top",   0, LB,  32'h2FFF, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step("sw10",     1, LW,  32'h10, 32'h12345678, 32'h0, 0, 1, 32'h10, 32'h12345678);
    step("lb13",     0, LB,  32'h13, 32'h0, 32'h00000012, 0, 0, 32'h10, 32'h12345678);
    step("lbu10",    0, LBU, 32'h10, 32'h0, 32'h00000078, 0, 0, 32'h10, 32'h12345678);
    step("lh12",     0, LH,  32'h12, 32'h0, 32'h00001234, 0, 0, 32'h10, 32'h12345678);
    step("lw10",     0, LW,  32'h10, 32'h0, 32'h12345678, 0, 0, 32'h10, 32'h12345678);
    step("sb11",     1, LB,  32'h11, 32'hFFFFFF80, 32'h00000056, 0, 1, 32'h10, 32'h12348078);
    step("sh12",     1, LH,  32'h12, 32'h0000BEEF, 32'h00001234, 0, 1, 32'h10, 32'hBEEF8078);
    step("lw10b",    0, LW,  32'h10, 32'h0, 32'hBEEF8078, 0, 0, 32'h10, 32'hBEEF8078);
    step("lb11",     0, LB,  32'h11, 32'h0, 32'hFFFFFF80, 0, 0, 32'h10, 32'hBEEF8078);
    step("lh12b",    0, LH,  32'h12, 32'h0, 32'hFFFFBEEF, 0, 0, 32'h10, 32'hBEEF8078);
    step("lhu12",    0, LHU, 32'h12, 32'h0, 32'h0000BEEF, 0, 0, 32'h10, 32'hBEEF8078);
    step("sw_mis",   1, LW,  32'h12, 32'hDEADDEAD, 32'h0, 1, 0, 32'h10, 32'hBEEF8078);
    step("sh_mis",   1, LHU, 32'h13, 32'hDEADDEAD, 32'h0, 1, 0, 32'h10, 32'hBEEF8078);
    step("sw_oor",   1, LW,  32'h3000, 32'hDEADDEAD, 32'h0, 1, 0, 32'h10, 32'hBEEF8078);
    step("sw_alias", 1, LW,  32'h3010, 32'hDEADDEAD, 32'h0, 1, 0, 32'h10, 32'hBEEF8078);
    step("sw_hi",    1, LW,  32'hFFFFFFFC, 32'hDEADDEAD, 32'h0, 1, 0, 32'h10, 32'hBEEF8078);
    step("op7",      1, 3'd7, 32'h10, 32'hDEADDEAD, 32'h0, 1, 0, 32'h10, 32'hBEEF8078);
    step("lw10c",    0, LW,  32'h10, 32'h0, 32'hBEEF8078, 0, 0, 32'h10, 32'hBEEF8078);
    step("sw20",     1, LW,  32'h20, 32'hA, 32'h0, 0, 1, 32'h20, 32'hA);
    step("sw24",     1, LW,  32'h24, 32'hB, 32'h0, 0, 1, 32'h24, 32'hB);
    step("lw20",     0, LW,  32'h20, 32'h0, 32'hA, 0, 0, 32'h24, 32'hB);
    step("sw28",     1, LW,  32'h28, 32'h5, 32'h0, 0, 1, 32'h28, 32'h5);
    #2;
    reset_n = 1'b0;
    #1;
    trace_zero("async_rst");
    @(negedge clk);
    we = 1'b1; mem_op = LW; addr = 32'h30; wdata = 32'h77;
    @(posedge clk);
    #1;
    trace_zero("rst_hold");
    @(negedge clk);
    we = 1'b0;
    reset_n = 1'b1;
    step("lw10_rst", 0, LW, 32'h10, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step("lw28_rst", 0, LW, 32'h28, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step("lw30_rst", 0, LW, 32'h30, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
